// File: rtl/apb_mig_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : apb_mig_ctrl
// Brief   : APB4 slave that sequences single-beat accesses onto the MIG native
//           application interface. Optional read watchdog: APB_MIG_RD_TIMEOUT_EN
// Revision: 1.0 - initial release
// ============================================================================
module apb_mig_ctrl #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned MIG_ADDR_WIDTH = 27,
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        psel_i,
    input  logic                        penable_i,
    input  logic                        pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0]   paddr_i,
    input  logic [31:0]                 pwdata_i,
    input  logic [3:0]                  pstrb_i,
    output logic [31:0]                 prdata_o,
    output logic                        pready_o,
    output logic                        pslverr_o,
    input  logic                        init_calib_complete_i,
    output logic [MIG_ADDR_WIDTH-1:0]   app_addr_o,
    output logic [2:0]                  app_cmd_o,
    output logic                        app_en_o,
    input  logic                        app_rdy_i,
    output logic [DATA_WIDTH-1:0]       app_wdf_data_o,
    output logic [DATA_WIDTH/8-1:0]     app_wdf_mask_o,
    output logic                        app_wdf_wren_o,
    output logic                        app_wdf_end_o,
    input  logic                        app_wdf_rdy_i,
    input  logic [DATA_WIDTH-1:0]       app_rd_data_i,
    input  logic                        app_rd_data_valid_i
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned LANES      = DATA_WIDTH / 32;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD_CMD  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [MIG_ADDR_WIDTH-1:0]  r_addr;
    logic [1:0]                 r_lane;
    logic [31:0]                r_wdata;
    logic [STRB_WIDTH-1:0]      r_mask;
    logic                       r_err;
    logic                       r_cmd_done;
    logic                       r_wdf_done;
    logic [31:0]                r_prdata;

    logic                       w_access;
    logic                       w_addr_err;
    logic                       w_cmd_fire;
    logic                       w_wdf_fire;
    logic                       w_rd_take;
    logic                       w_timeout;
    logic                       w_stale;
    logic [STRB_WIDTH-1:0]      w_mask;

    assign w_access   = psel_i & penable_i & init_calib_complete_i;
    assign w_addr_err = (paddr_i[APB_ADDR_WIDTH-1:MIG_ADDR_WIDTH+1] != '0) ||
                        (paddr_i[1:0] != 2'b00);
    // Strobe shift of 4 bits per lane mirrors the controller's lane mapping.
    assign w_mask     = ~({{(STRB_WIDTH-4){1'b0}}, pstrb_i} << {paddr_i[3:2], 2'b00});
    assign w_cmd_fire = app_en_o & app_rdy_i;
    assign w_wdf_fire = app_wdf_wren_o & app_wdf_rdy_i;
    assign w_rd_take  = (r_state == S_RD_WAIT) & app_rd_data_valid_i & ~w_stale;

`ifdef APB_MIG_RD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_stale;

    assign w_timeout = ((r_state == S_RD_CMD) || (r_state == S_RD_WAIT)) &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_stale   = r_stale;

    // A read abandoned after its command was accepted still owes one data beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
            r_stale   <= 1'b0;
        end else begin
            if ((r_state == S_RD_CMD) || (r_state == S_RD_WAIT))
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            else
                r_tmo_cnt <= '0;
            if (r_stale && app_rd_data_valid_i)
                r_stale <= 1'b0;
            else if (w_timeout && !w_rd_take && ((r_state == S_RD_WAIT) || w_cmd_fire))
                r_stale <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_stale   = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_access)
                    w_next = w_addr_err ? S_DONE : (pwrite_i ? S_WR : S_RD_CMD);
            end
            S_WR: begin
                if ((r_cmd_done | w_cmd_fire) && (r_wdf_done | w_wdf_fire))
                    w_next = S_DONE;
            end
            S_RD_CMD: begin
                if (w_timeout)
                    w_next = S_DONE;
                else if (app_rdy_i)
                    w_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (w_rd_take || w_timeout)
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_lane     <= '0;
            r_wdata    <= '0;
            r_mask     <= '0;
            r_err      <= 1'b0;
            r_cmd_done <= 1'b0;
            r_wdf_done <= 1'b0;
            r_prdata   <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && w_access) begin
                r_addr     <= {paddr_i[MIG_ADDR_WIDTH:4], 3'b000};
                r_lane     <= paddr_i[3:2];
                r_wdata    <= pwdata_i;
                r_mask     <= w_mask;
                r_err      <= w_addr_err;
                r_cmd_done <= 1'b0;
                r_wdf_done <= 1'b0;
            end
            if ((r_state == S_WR) && w_cmd_fire)
                r_cmd_done <= 1'b1;
            if ((r_state == S_WR) && w_wdf_fire)
                r_wdf_done <= 1'b1;
            if (w_rd_take) begin
                r_prdata <= app_rd_data_i[32*r_lane +: 32];
            end else if (w_timeout) begin
                r_prdata <= 32'hDEAD_BEEF;
                r_err    <= 1'b1;
            end
        end
    end

    assign prdata_o       = r_prdata;
    assign pready_o       = (r_state == S_DONE);
    assign pslverr_o      = (r_state == S_DONE) & r_err;
    assign app_addr_o     = r_addr;
    assign app_cmd_o      = (r_state == S_RD_CMD) ? 3'b001 : 3'b000;
    assign app_en_o       = ((r_state == S_WR) & ~r_cmd_done) | (r_state == S_RD_CMD);
    assign app_wdf_wren_o = (r_state == S_WR) & ~r_wdf_done;
    assign app_wdf_end_o  = app_wdf_wren_o;
    assign app_wdf_data_o = {LANES{r_wdata}};
    assign app_wdf_mask_o = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_apb_mig_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_mig_ctrl
// Brief   : Directed self-checking bench for apb_mig_ctrl with a MIG responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_apb_mig_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         psel_i, penable_i, pwrite_i;
    logic [31:0]  paddr_i, pwdata_i;
    logic [3:0]   pstrb_i;
    logic [31:0]  prdata_o;
    logic         pready_o, pslverr_o;
    logic         init_calib_complete_i;
    logic [26:0]  app_addr_o;
    logic [2:0]   app_cmd_o;
    logic         app_en_o, app_rdy_i;
    logic [127:0] app_wdf_data_o;
    logic [15:0]  app_wdf_mask_o;
    logic         app_wdf_wren_o, app_wdf_end_o, app_wdf_rdy_i;
    logic [127:0] app_rd_data_i;
    logic         app_rd_data_valid_i;

    apb_mig_ctrl #(
        .APB_ADDR_WIDTH (32),
        .MIG_ADDR_WIDTH (27),
        .DATA_WIDTH     (128),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .psel_i                (psel_i),
        .penable_i             (penable_i),
        .pwrite_i              (pwrite_i),
        .paddr_i               (paddr_i),
        .pwdata_i              (pwdata_i),
        .pstrb_i               (pstrb_i),
        .prdata_o              (prdata_o),
        .pready_o              (pready_o),
        .pslverr_o             (pslverr_o),
        .init_calib_complete_i (init_calib_complete_i),
        .app_addr_o            (app_addr_o),
        .app_cmd_o             (app_cmd_o),
        .app_en_o              (app_en_o),
        .app_rdy_i             (app_rdy_i),
        .app_wdf_data_o        (app_wdf_data_o),
        .app_wdf_mask_o        (app_wdf_mask_o),
        .app_wdf_wren_o        (app_wdf_wren_o),
        .app_wdf_end_o         (app_wdf_end_o),
        .app_wdf_rdy_i         (app_wdf_rdy_i),
        .app_rd_data_i         (app_rd_data_i),
        .app_rd_data_valid_i   (app_rd_data_valid_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // responder configuration and observation counters
    int           cfg_cmd_dly = 0, cfg_wdf_dly = 0, cfg_rd_dly = 1;
    bit           cfg_rd_drop = 1'b0;
    logic [127:0] cfg_rd_data = '0;
    int           en_cyc = 0, wren_cyc = 0, pready_cyc = 0, cmd_acc = 0, wdf_acc = 0;
    int           cmd_wait = 0, wdf_wait = 0, rd_cnt = 0;
    logic [2:0]   last_cmd = '0;
    logic [26:0]  last_addr = '0;
    logic [15:0]  last_mask = '0;
    logic [127:0] last_wdata = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // MIG responder: decides rdy/valid at negedge for the following posedge.
    initial begin
        app_rdy_i = 1'b0;
        app_wdf_rdy_i = 1'b0;
        app_rd_data_valid_i = 1'b0;
        app_rd_data_i = '0;
        forever begin
            @(negedge clk_i);
            en_cyc     += int'(app_en_o);
            wren_cyc   += int'(app_wdf_wren_o);
            pready_cyc += int'(pready_o);
            app_rd_data_valid_i = 1'b0;
            app_rd_data_i = '0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    app_rd_data_valid_i = 1'b1;
                    app_rd_data_i = cfg_rd_data;
                end
            end
            if (app_en_o) begin
                app_rdy_i = (cmd_wait >= cfg_cmd_dly);
                if (app_rdy_i) begin
                    cmd_wait = 0;
                    cmd_acc++;
                    last_cmd  = app_cmd_o;
                    last_addr = app_addr_o;
                    if (app_cmd_o == 3'b001 && !cfg_rd_drop) rd_cnt = cfg_rd_dly;
                end else begin
                    cmd_wait++;
                end
            end else begin
                app_rdy_i = 1'b0;
                cmd_wait = 0;
            end
            if (app_wdf_wren_o) begin
                if (app_wdf_end_o !== 1'b1) check("wdf_end", app_wdf_end_o, 1);
                app_wdf_rdy_i = (wdf_wait >= cfg_wdf_dly);
                if (app_wdf_rdy_i) begin
                    wdf_wait = 0;
                    wdf_acc++;
                    last_mask  = app_wdf_mask_o;
                    last_wdata = app_wdf_data_o;
                end else begin
                    wdf_wait++;
                end
            end else begin
                app_wdf_rdy_i = 1'b0;
                wdf_wait = 0;
            end
        end
    end

    // lat counts access-phase cycles up to and including the pready cycle
    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output logic err, output int lat);
        bit done = 1'b0;
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
        paddr_i = addr; pwdata_i = wdata; pstrb_i = strb;
        @(negedge clk_i);
        penable_i = 1'b1;
        lat = 1;
        while (!done && lat < 300) begin
            @(negedge clk_i);
            lat++;
            if (pready_o) done = 1'b1;
        end
        rdata = prdata_o;
        err   = pslverr_o;
        if (!done) check("apb_timeout", 0, 1);
        psel_i = 1'b0; penable_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, e0, w0, p0, c0, n;

        rst_i = 1'b1; init_calib_complete_i = 1'b1;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        paddr_i = '0; pwdata_i = '0; pstrb_i = '0;
        repeat (3) @(negedge clk_i);
        check("reset_ctrl", {pready_o, pslverr_o, app_en_o, app_wdf_wren_o, app_wdf_end_o, app_cmd_o}, 0);
        check("reset_addr", app_addr_o, 0);
        check("reset_wdata", app_wdf_data_o, 0);
        check("reset_mask", app_wdf_mask_o, 0);
        check("reset_prdata", prdata_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // basic write, all rdy high
        e0 = en_cyc; w0 = wren_cyc; p0 = pready_cyc;
        apb_xfer(1, 32'h0000_0014, 32'hA5A5_1234, 4'b1111, rd, er, lat);
        check("wr_lat", lat, 3);
        check("wr_err", er, 0);
        check("wr_en_cycles", en_cyc - e0, 1);
        check("wr_wren_cycles", wren_cyc - w0, 1);
        check("wr_pready_pulses", pready_cyc - p0, 1);
        check("wr_cmd", last_cmd, 3'b000);
        check("wr_addr", last_addr, 27'h8);
        check("wr_mask", last_mask, 16'hFF0F);
        check("wr_data", last_wdata, {4{32'hA5A5_1234}});

        // read, data 5 cycles after command
        cfg_rd_dly = 5;
        cfg_rd_data = {32'h1111_1111, 32'hCAFE_F00D, 32'h3333_3333, 32'h4444_4444};
        p0 = pready_cyc;
        apb_xfer(0, 32'h0000_0018, 32'h0, 4'h0, rd, er, lat);
        check("rd_data", rd, 32'hCAFE_F00D);
        check("rd_err", er, 0);
        check("rd_lat", lat, 8);
        check("rd_pready_pulses", pready_cyc - p0, 1);
        check("rd_cmd", last_cmd, 3'b001);
        check("rd_addr", last_addr, 27'h8);

        // minimum-latency read, lane 0
        cfg_rd_dly = 1;
        cfg_rd_data = {32'h1, 32'h2, 32'h3, 32'h0BAD_C0DE};
        apb_xfer(0, 32'h0000_0000, 32'h0, 4'h0, rd, er, lat);
        check("rd_min_lat", lat, 4);
        check("rd_lane0", rd, 32'h0BAD_C0DE);

        // command accepted 2 cycles after write data
        cfg_cmd_dly = 2; cfg_wdf_dly = 0;
        e0 = en_cyc; w0 = wren_cyc;
        apb_xfer(1, 32'h0000_0024, 32'h0102_0304, 4'b0011, rd, er, lat);
        check("wr_cmdlate_en", en_cyc - e0, 3);
        check("wr_cmdlate_wren", wren_cyc - w0, 1);
        check("wr_cmdlate_lat", lat, 5);
        check("wr_cmdlate_mask", last_mask, 16'hFFCF);
        check("wr_cmdlate_addr", last_addr, 27'h10);

        // write data accepted 2 cycles after command
        cfg_cmd_dly = 0; cfg_wdf_dly = 2;
        e0 = en_cyc; w0 = wren_cyc;
        apb_xfer(1, 32'h0000_003C, 32'hFFEE_DDCC, 4'b1000, rd, er, lat);
        check("wr_wdflate_en", en_cyc - e0, 1);
        check("wr_wdflate_wren", wren_cyc - w0, 3);
        check("wr_wdflate_lat", lat, 5);
        check("wr_wdflate_mask", last_mask, 16'h7FFF);
        check("wr_wdflate_addr", last_addr, 27'h18);
        cfg_wdf_dly = 0;

        // zero strobes still issue the command
        e0 = en_cyc;
        apb_xfer(1, 32'h0000_0000, 32'h5555_AAAA, 4'b0000, rd, er, lat);
        check("wr_nostrb_en", en_cyc - e0, 1);
        check("wr_nostrb_mask", last_mask, 16'hFFFF);

        // address errors: out of range and misaligned
        e0 = en_cyc; w0 = wren_cyc;
        apb_xfer(0, 32'h1000_0000, 32'h0, 4'h0, rd, er, lat);
        check("err_range_slverr", er, 1);
        check("err_range_lat", lat, 2);
        apb_xfer(1, 32'h0000_0002, 32'h1234_5678, 4'hF, rd, er, lat);
        check("err_align_slverr", er, 1);
        check("err_no_mig_en", en_cyc - e0, 0);
        check("err_no_mig_wren", wren_cyc - w0, 0);
        check("prdata_held", prdata_o, 32'h0BAD_C0DE);

        // calibration pending for 20 cycles
        init_calib_complete_i = 1'b0;
        e0 = en_cyc; p0 = pready_cyc;
        fork
            apb_xfer(1, 32'h0000_0040, 32'h1234_5678, 4'hF, rd, er, lat);
            begin
                repeat (20) @(negedge clk_i);
                #1;
                check("calib_no_mig", en_cyc - e0, 0);
                check("calib_no_pready", pready_cyc - p0, 0);
                init_calib_complete_i = 1'b1;
            end
        join
        check("calib_done_en", en_cyc - e0, 1);
        check("calib_done_err", er, 0);
        check("calib_done_addr", last_addr, 27'h20);

        // reset while waiting for read data
        cfg_rd_dly = 5;
        cfg_rd_data = {32'h7777_7777, 32'h6666_6666, 32'h5555_5555, 32'h4444_4444};
        c0 = cmd_acc;
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 32'h0000_0024;
        @(negedge clk_i);
        penable_i = 1'b1;
        n = 0;
        while (cmd_acc == c0 && n < 50) begin
            @(negedge clk_i); #1; n++;
        end
        check("rst_cmd_seen", (cmd_acc != c0), 1);
        @(negedge clk_i);
        rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0;
        p0 = pready_cyc;
        @(negedge clk_i);
        check("rst_mid_ctrl", {pready_o, pslverr_o, app_en_o, app_wdf_wren_o, app_wdf_end_o, app_cmd_o}, 0);
        check("rst_mid_addr", app_addr_o, 0);
        check("rst_mid_mask", app_wdf_mask_o, 0);
        check("rst_mid_prdata", prdata_o, 0);
        rst_i = 1'b0;
        repeat (8) @(negedge clk_i);
        check("rst_late_prdata", prdata_o, 0);
        check("rst_late_pready", pready_cyc - p0, 0);

        cfg_rd_dly = 1;
        apb_xfer(0, 32'h0000_0024, 32'h0, 4'h0, rd, er, lat);
        check("post_rst_rd", rd, 32'h5555_5555);
        check("post_rst_err", er, 0);

`ifdef APB_MIG_RD_TIMEOUT_EN
        // read data never returns
        cfg_rd_drop = 1'b1;
        apb_xfer(0, 32'h0000_0008, 32'h0, 4'h0, rd, er, lat);
        check("tmo_slverr", er, 1);
        check("tmo_prdata", rd, 32'hDEAD_BEEF);
        cfg_rd_drop = 1'b0;
`endif

        repeat (3) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_mig_ctrl.md
Name: apb_mig_ctrl

Overview:
APB4 slave that turns single 32-bit APB accesses into single-beat transactions on the MIG native application interface (128-bit data, 27-bit address). It handles command/write-data handshakes, byte masks and read-lane selection. Accesses stall until the MIG signals calibration complete. It is the sequencer between the SoC APB fabric and the DDR controller user-interface clock domain; the APB side is already synchronous to the MIG ui clock.

Parameters:
APB_ADDR_WIDTH, 32, APB address width
MIG_ADDR_WIDTH, 27, MIG app_addr width
DATA_WIDTH, 128, MIG data width; STRB_WIDTH = DATA_WIDTH/8 = 16
TIMEOUT_CYCLES, 1024, read watchdog limit (used only with the optional feature)

Ports:
clk_i  in  1  clock (MIG ui_clk)
rst_i  in  1  synchronous, active-high reset
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  APB direction
paddr_i  in  APB_ADDR_WIDTH  byte address
pwdata_i  in  32  write data
pstrb_i  in  4  write byte strobes
prdata_o  out  32  read data
pready_o  out  1  transfer complete
pslverr_o  out  1  error response
init_calib_complete_i  in  1  MIG calibration done
app_addr_o  out  MIG_ADDR_WIDTH  MIG address
app_cmd_o  out  3  3'b000 write, 3'b001 read
app_en_o  out  1  command valid
app_rdy_i  in  1  command accepted
app_wdf_data_o  out  DATA_WIDTH  write data
app_wdf_mask_o  out  STRB_WIDTH  byte mask (1 = byte not written)
app_wdf_wren_o  out  1  write data valid
app_wdf_end_o  out  1  last beat; equals app_wdf_wren_o
app_wdf_rdy_i  in  1  write data accepted
app_rd_data_i  in  DATA_WIDTH  read data
app_rd_data_valid_i  in  1  read data valid

Behaviour:
- Reset: all outputs 0 (prdata_o, pready_o, pslverr_o, app_en_o, app_wdf_wren_o, app_wdf_end_o, app_addr_o, app_cmd_o, app_wdf_data_o, app_wdf_mask_o); FSM to IDLE. Reset mid-operation aborts immediately. Read data arriving after reset is ignored.
- Address map: app_addr_o = {paddr_i[MIG_ADDR_WIDTH:4], 3'b000}; lane = paddr_i[3:2].
- Error: paddr_i[APB_ADDR_WIDTH-1:MIG_ADDR_WIDTH+1] != 0 or paddr_i[1:0] != 0.
- FSM states: IDLE, WR, RD_CMD, RD_WAIT, DONE.
- IDLE: when psel_i & penable_i & init_calib_complete_i:
  - latch address, lane, data, strobes, direction;
  - on error, go to DONE with pslverr set and no MIG traffic;
  - otherwise go to WR if pwrite_i, else RD_CMD.
  - Without calibration, stay in IDLE with pready_o = 0.
- WR:
  - Assert app_en_o (cmd 000) and app_wdf_wren_o/app_wdf_end_o together.
  - app_wdf_data_o = pwdata replicated 4×.
  - app_wdf_mask_o = ~(pstrb << 4*lane).
  - Command and data handshakes complete independently. Each valid drops the cycle after its own rdy is sampled high, tracked by flags cmd_done/wdf_done.
  - Go to DONE when both are done, including when both complete in the same cycle.
  - pstrb = 0: still issue the command, with mask all ones.
- RD_CMD: assert app_en_o (cmd 001) until app_rdy_i, then go to RD_WAIT.
- RD_WAIT: on app_rd_data_valid_i, latch prdata_o = app_rd_data_i[32*lane +: 32], then go to DONE.
- DONE: pready_o = 1 for exactly one cycle; pslverr_o valid only in that cycle; then IDLE. prdata_o holds its value until the next read.
- Minimum latency (access phase start to pready, all rdy high): write 3 cycles, read 4 cycles with read data valid the cycle after the command is accepted.
- app_addr_o/app_cmd_o stay stable while app_en_o is high. Wait states may be arbitrarily long.
- Only one outstanding transaction; APB never sees back-to-back completion without a new setup phase.

Optional Feature:
APB_MIG_RD_TIMEOUT_EN
- Defined: a counter starts on entry to RD_CMD. If TIMEOUT_CYCLES elapse without the read completing, go to DONE with pslverr_o = 1 and prdata_o = 32'hDEAD_BEEF. A late app_rd_data_valid_i for that read is discarded.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Write paddr=0x0000_0014, pwdata=0xA5A5_1234, pstrb=4'b1111, rdy always 1 -> one app_en with cmd 000, app_addr=0x0000008, mask=16'hFF0F, pready after 3 cycles, pslverr=0.
- Read paddr=0x0000_0018, app_rd_data lane2 = 0xCAFE_F00D, valid 5 cycles after cmd -> prdata=0xCAFE_F00D, one pready pulse, pslverr=0.
- Write with app_rdy_i high 2 cycles after app_wdf_rdy_i (and the reverse order) -> each valid held until its own handshake, pready only after both.
- paddr=0x1000_0000 or paddr=0x0000_0002 -> pready with pslverr=1, app_en/app_wdf_wren never asserted.
- init_calib_complete_i low 20 cycles during an access -> pready low, no MIG traffic; access completes after calibration.
- rst_i asserted in RD_WAIT, then valid returns -> all outputs 0, prdata unchanged, next read completes normally. With APB_MIG_RD_TIMEOUT_EN and TIMEOUT_CYCLES=16, no valid returned -> pslverr=1, prdata=0xDEAD_BEEF.
